// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with valid/ready backpressure.
// Shift levels are spread over NUM_STAGES registered stages; tag rides along.
module pipe_shifter #(
  parameter int WIDTH      = 32,
  parameter int SHAMT_W    = $clog2(WIDTH),
  parameter int NUM_STAGES = 2,
  parameter int TAG_W      = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [2:0]         i_op,
  input  logic [WIDTH-1:0]   i_operand_a,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [TAG_W-1:0]   i_tag,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WIDTH-1:0]   o_result,
  output logic [TAG_W-1:0]   o_tag
);

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  typedef struct packed {
    logic [WIDTH-1:0]   data;
    logic [2:0]         op;
    logic [SHAMT_W-1:0] shamt;
    logic               sign;
    logic [TAG_W-1:0]   tag;
  } stage_t;

  // One mux level: shift/rotate by 2^j. Reserved ops pass data through.
  function automatic logic [WIDTH-1:0] shift_lvl(input logic [WIDTH-1:0] d,
                                                 input logic [2:0] op,
                                                 input logic sign,
                                                 input int j);
    int amt;
    logic [WIDTH-1:0] fill;
    amt  = 1 << j;
    fill = sign ? ~({WIDTH{1'b1}} >> amt) : '0;
    case (op)
      OP_SLL:  return d << amt;
      OP_SRL:  return d >> amt;
      OP_SRA:  return (d >> amt) | fill;
      OP_ROL:  return (d << amt) | (d >> (WIDTH - amt));
      OP_ROR:  return (d >> amt) | (d << (WIDTH - amt));
      default: return d;
    endcase
  endfunction

  // Apply the levels owned by stage k: level j lives in stage j*NUM_STAGES/SHAMT_W.
  function automatic stage_t run_levels(input stage_t s, input int k);
    stage_t r;
    r = s;
    for (int j = 0; j < SHAMT_W; j++)
      if (((j * NUM_STAGES) / SHAMT_W) == k && r.shamt[j])
        r.data = shift_lvl(r.data, r.op, r.sign, j);
    return r;
  endfunction

  stage_t                  in_s;
  stage_t                  stg_q [NUM_STAGES];
  stage_t                  nxt   [NUM_STAGES];
  logic [NUM_STAGES-1:0]   vld_pipe;
  logic [NUM_STAGES-1:0]   up_vld;
  logic [NUM_STAGES-1:0]   adv;

  // Sign is latched here so SRA never depends on already-shifted data.
  assign in_s = '{data: i_operand_a, op: i_op, shamt: i_shamt,
                  sign: i_operand_a[WIDTH-1], tag: i_tag};

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stg
    if (k == 0) begin : g_first
      assign nxt[k]    = run_levels(in_s, k);
      assign up_vld[k] = i_valid;
    end else begin : g_rest
      assign nxt[k]    = run_levels(stg_q[k-1], k);
      assign up_vld[k] = vld_pipe[k-1];
    end
    // A stage moves when any stage at or below it has a hole, or the sink takes one.
    assign adv[k] = ~(&vld_pipe[NUM_STAGES-1:k]) | i_ready;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vld_pipe <= '0;
      for (int k = 0; k < NUM_STAGES; k++) stg_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (adv[k]) begin
          vld_pipe[k] <= up_vld[k];
          if (up_vld[k]) stg_q[k] <= nxt[k];
        end
      end
    end
  end

  assign o_ready  = adv[0];
  assign o_valid  = vld_pipe[NUM_STAGES-1];
  assign o_result = stg_q[NUM_STAGES-1].data;
  assign o_tag    = stg_q[NUM_STAGES-1].tag;

endmodule
